// File: rtl/data_io_loader.sv
// IO-controller SPI download engine: decodes file-transfer commands, buffers
// memory writes in a small FIFO and runs a paced erase of a memory range.
module data_io_loader #(
  parameter int              AW           = 25,
  parameter int              FIFO_DEPTH   = 4,
  parameter logic [AW-1:0]   ROM_BASE     = 25'h200000,
  parameter logic [AW-1:0]   TAPE_BASE    = 25'h100000,
  parameter int              JMP_PATCH    = 1,
  parameter logic [AW-1:0]   ERASE_START  = 25'h1a0000,
  parameter logic [AW-1:0]   ERASE_END    = 25'h1c0000,
  parameter int              ERASE_DIV    = 32,
  parameter int              ERASE_ON_ROM = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sck,
  input  logic          ss,
  input  logic          sdi,
  input  logic          force_erase,
  input  logic          ready,
  output logic          downloading,
  output logic [AW-1:0] size,
  output logic [4:0]    index,
  output logic          wr,
  output logic [AW-1:0] a,
  output logic [7:0]    d,
  output logic          overflow,
  output logic [1:0]    erase_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int DW = (ERASE_DIV > 1) ? $clog2(ERASE_DIV) : 1;

  typedef enum logic [1:0] {E_IDLE = 2'd0, E_WAIT = 2'd1, E_RUN = 2'd2} erase_state_t;

  // SPI synchronisers; sck keeps a third stage for edge detection
  logic [2:0] sck_q;
  logic [1:0] ss_q, sdi_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_q <= '0;
      ss_q  <= '0;
      sdi_q <= '0;
    end else begin
      sck_q <= {sck_q[1:0], sck};
      ss_q  <= {ss_q[0], ss};
      sdi_q <= {sdi_q[0], sdi};
    end
  end

  logic sck_rise, ss_s;
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign ss_s     = ss_q[1];

  // armed stays low after reset until ss is seen high, so a transfer cut by
  // reset is never reinterpreted with a shifted byte boundary
  logic       armed, have_cmd;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic [7:0] cmd, rx_byte;
  logic       data_stb;
  assign rx_byte  = {shift, sdi_q[1]};
  assign data_stb = armed && !ss_s && sck_rise && (bit_cnt == 3'd7) && have_cmd;

  always_ff @(posedge clk) begin
    if (reset) begin
      armed    <= 1'b0;
      have_cmd <= 1'b0;
      bit_cnt  <= '0;
      shift    <= '0;
      cmd      <= '0;
    end else if (ss_s) begin
      armed    <= 1'b1;
      have_cmd <= 1'b0;
      bit_cnt  <= '0;
    end else if (armed && sck_rise) begin
      shift   <= rx_byte[6:0];
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7 && !have_cmd) begin
        cmd      <= rx_byte;
        have_cmd <= 1'b1;
      end
    end
  end

  logic tx_start, tx_end, dat_stb, idx_stb;
  assign tx_start = data_stb && (cmd == 8'h53) && rx_byte[0];
  assign tx_end   = data_stb && (cmd == 8'h53) && !rx_byte[0];
  assign dat_stb  = data_stb && (cmd == 8'h54);
  assign idx_stb  = data_stb && (cmd == 8'h55);

  logic [AW-1:0] ptr;
  logic [1:0]    hdr_cnt;
  logic [7:0]    load_hi, load_lo;
  logic          dl;
  logic          patch;
  logic [AW-1:0] push_a;
  logic [7:0]    push_d;
  logic          payload;
  assign patch = (JMP_PATCH != 0) && (index != 5'd0) && (hdr_cnt != 2'd3);

  // tape header becomes a JP to the load address in the first three bytes
  always_comb begin
    push_a  = ptr;
    push_d  = rx_byte;
    payload = 1'b1;
    if (patch) begin
      payload = 1'b0;
      case (hdr_cnt)
        2'd0:    begin push_a = '0;     push_d = 8'hC3;   end
        2'd1:    begin push_a = AW'(1);                   end
        default: begin push_a = AW'(2); push_d = load_hi; end
      endcase
    end
  end

  logic [AW+7:0] mem [FIFO_DEPTH];
  logic [PW:0]   wp, rp;
  logic          empty, full, pop, push_ok;
  logic [AW+7:0] head;
  assign empty   = (wp == rp);
  assign full    = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign pop     = !empty && ready;
  assign push_ok = dat_stb && (!full || pop);
  assign head    = mem[rp[PW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp[PW-1:0]] <= {push_a, push_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp       <= '0;
      rp       <= '0;
      ptr      <= '0;
      size     <= '0;
      hdr_cnt  <= '0;
      load_hi  <= '0;
      load_lo  <= '0;
      dl       <= 1'b0;
      index    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) rp <= rp + 1'b1;
      if (push_ok) wp <= wp + 1'b1;
      if (dat_stb && !push_ok) overflow <= 1'b1;
      if (push_ok && payload) size <= size + 1'b1;
      if (dat_stb) begin
        if (patch) begin
          hdr_cnt <= hdr_cnt + 2'd1;
          case (hdr_cnt)
            2'd0:    load_hi <= rx_byte;
            2'd1:    load_lo <= rx_byte;
            default: ptr     <= AW'({load_hi, load_lo});
          endcase
        end else begin
          ptr <= ptr + 1'b1;
        end
      end
      if (tx_start) begin
        ptr     <= (index == 5'd0) ? ROM_BASE : TAPE_BASE;
        size    <= '0;
        hdr_cnt <= '0;
        dl      <= 1'b1;
      end
      if (tx_end) dl <= 1'b0;
      if (idx_stb) index <= rx_byte[4:0];
    end
  end

  erase_state_t  state, next_state;
  logic [AW-1:0] erase_addr;
  logic [DW-1:0] div_cnt;
  logic          force_q, erase_req, erase_wr, erase_acc;
  assign erase_req = (tx_end && (ERASE_ON_ROM != 0) && (index == 5'd0)) ||
                     (force_erase && !force_q);
  assign erase_wr  = (state == E_RUN) && (div_cnt == '0) && empty;
  assign erase_acc = erase_wr && ready;

  always_comb begin
    next_state = state;
    case (state)
      E_IDLE: if (erase_req) next_state = E_WAIT;
      E_WAIT: if (!dl && empty) next_state = E_RUN;
      E_RUN: begin
        if (tx_start) next_state = E_IDLE;
        else if (erase_acc && erase_addr == ERASE_END) next_state = E_IDLE;
      end
      default: next_state = E_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= E_IDLE;
      force_q    <= 1'b0;
      erase_addr <= '0;
      div_cnt    <= '0;
    end else begin
      state   <= next_state;
      force_q <= force_erase;
      if (state == E_WAIT && next_state == E_RUN) begin
        erase_addr <= ERASE_START;
        div_cnt    <= '0;
      end else if (state == E_RUN) begin
        if (erase_acc) begin
          erase_addr <= erase_addr + 1'b1;
          div_cnt    <= DW'(ERASE_DIV - 1);
        end else if (div_cnt != '0) begin
          div_cnt <= div_cnt - 1'b1;
        end
      end
    end
  end

  assign wr          = !empty || erase_wr;
  assign a           = !empty ? head[AW+7:8] : (erase_wr ? erase_addr : '0);
  assign d           = !empty ? head[7:0] : 8'h00;
  assign downloading = dl || (state != E_IDLE) || !empty;
  assign erase_state = state;

endmodule

// File: tb/tb_data_io_loader.sv
// Directed bench for data_io_loader: SPI command driver, write monitor and
// per-scenario checks against hand-computed write sequences.
module tb_data_io_loader;
  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          reset, sck, ss, sdi, force_erase, ready;
  logic          downloading, wr, overflow;
  logic [AW-1:0] size, a;
  logic [4:0]    index;
  logic [7:0]    d;
  logic [1:0]    erase_state;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [AW+7:0] exp_q[$];
  logic [AW+7:0] obs_q[$];
  int            obs_t[$];

  data_io_loader #(
    .AW(AW), .FIFO_DEPTH(4), .ROM_BASE(25'h200000), .TAPE_BASE(25'h100000),
    .JMP_PATCH(1), .ERASE_START(25'h1a0000), .ERASE_END(25'h1a0003),
    .ERASE_DIV(2), .ERASE_ON_ROM(1)
  ) dut (
    .clk(clk), .reset(reset), .sck(sck), .ss(ss), .sdi(sdi),
    .force_erase(force_erase), .ready(ready), .downloading(downloading),
    .size(size), .index(index), .wr(wr), .a(a), .d(d), .overflow(overflow),
    .erase_state(erase_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // every accepted write is recorded with its cycle number
  always @(negedge clk) begin
    if (wr === 1'b1 && ready === 1'b1) begin
      obs_q.push_back({a, d});
      obs_t.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
  endtask

  // driver tasks
  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sdi = b[i];
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b);
    spi_bits(b, 8);
  endtask

  task automatic spi_begin();
    ss = 1'b0;
    #40;
  endtask

  task automatic spi_end();
    #40 ss = 1'b1;
    #80;
  endtask

  task automatic spi_cmd1(input logic [7:0] c, input logic [7:0] b);
    spi_begin();
    spi_byte(c);
    spi_byte(b);
    spi_end();
  endtask

  task automatic wait_idle(input int max_cycles, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick(1);
      if (downloading === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if (wr !== 1'b0) begin tests_failed++; $display("FAIL reset_wr got %b want 0", wr); end
    tests_run++;
    if (size !== '0) begin tests_failed++; $display("FAIL reset_size got %h want 0", size); end
    tests_run++;
    if (index !== 5'd0) begin tests_failed++; $display("FAIL reset_index got %h want 0", index); end
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %b want 0", overflow); end
    tests_run++;
    if (downloading !== 1'b0) begin tests_failed++; $display("FAIL reset_downloading got %b want 0", downloading); end
    tests_run++;
    if (erase_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state got %0d want 0", erase_state); end
  endtask

  task automatic test_rom_download();
    logic ok;
    obs_q.delete(); obs_t.delete(); exp_q.delete();
    ready = 1'b1;
    spi_cmd1(8'h53, 8'h01);
    spi_begin();
    spi_byte(8'h54); spi_byte(8'hAA); spi_byte(8'hBB); spi_byte(8'hCC);
    spi_end();
    spi_cmd1(8'h53, 8'h00);
    wait_idle(2000, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL rom_idle_timeout got busy want idle"); end
    exp_q = '{{25'h200000, 8'hAA}, {25'h200001, 8'hBB}, {25'h200002, 8'hCC},
              {25'h1a0000, 8'h00}, {25'h1a0001, 8'h00}, {25'h1a0002, 8'h00},
              {25'h1a0003, 8'h00}};
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL rom_write_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++; $display("FAIL rom_write[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int i = 4; i < 7 && i < obs_t.size(); i++) begin
      tests_run++;
      if (obs_t[i] - obs_t[i-1] != 2) begin
        tests_failed++; $display("FAIL rom_erase_spacing[%0d] got %0d want 2", i, obs_t[i] - obs_t[i-1]);
      end
    end
    tests_run++;
    if (size !== 25'd3) begin tests_failed++; $display("FAIL rom_size got %0d want 3", size); end
  endtask

  task automatic test_tape_patch();
    logic ok;
    spi_cmd1(8'h55, 8'h01);
    tests_run++;
    if (index !== 5'd1) begin tests_failed++; $display("FAIL tape_index got %h want 1", index); end
    obs_q.delete(); obs_t.delete(); exp_q.delete();
    ready = 1'b1;
    spi_cmd1(8'h53, 8'h01);
    spi_begin();
    spi_byte(8'h54); spi_byte(8'h12); spi_byte(8'h34); spi_byte(8'hFF);
    spi_byte(8'h56); spi_byte(8'h78);
    spi_end();
    spi_cmd1(8'h53, 8'h00);
    wait_idle(500, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL tape_idle_timeout got busy want idle"); end
    exp_q = '{{25'h0, 8'hC3}, {25'h1, 8'h34}, {25'h2, 8'h12},
              {25'h1234, 8'h56}, {25'h1235, 8'h78}};
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL tape_write_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++; $display("FAIL tape_write[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    tests_run++;
    if (size !== 25'd2) begin tests_failed++; $display("FAIL tape_size got %0d want 2", size); end
  endtask

  task automatic test_overflow();
    logic ok;
    obs_q.delete(); obs_t.delete(); exp_q.delete();
    ready = 1'b0;
    spi_cmd1(8'h53, 8'h01);
    spi_begin();
    spi_byte(8'h54);
    for (int i = 1; i <= 6; i++) spi_byte(8'(i));
    spi_end();
    spi_cmd1(8'h53, 8'h00);
    tests_run++;
    if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag got %b want 1", overflow); end
    tests_run++;
    if (wr !== 1'b1 || a !== 25'h0 || d !== 8'hC3) begin
      tests_failed++; $display("FAIL ovf_head got wr=%b a=%h d=%h want wr=1 a=0 d=c3", wr, a, d);
    end
    tick(20);
    tests_run++;
    if (wr !== 1'b1 || a !== 25'h0 || d !== 8'hC3) begin
      tests_failed++; $display("FAIL ovf_hold got wr=%b a=%h d=%h want wr=1 a=0 d=c3", wr, a, d);
    end
    ready = 1'b1;
    wait_idle(200, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL ovf_idle_timeout got busy want idle"); end
    exp_q = '{{25'h0, 8'hC3}, {25'h1, 8'h02}, {25'h2, 8'h01}, {25'h0102, 8'h04}};
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL ovf_write_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++; $display("FAIL ovf_write[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    tests_run++;
    if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_force_erase();
    logic ok;
    do_reset();
    obs_q.delete(); obs_t.delete(); exp_q.delete();
    ready = 1'b1;
    spi_cmd1(8'h53, 8'h01);
    force_erase = 1'b1;
    tick(2);
    force_erase = 1'b0;
    tick(2);
    tests_run++;
    if (erase_state !== 2'd1) begin tests_failed++; $display("FAIL force_wait got %0d want 1", erase_state); end
    spi_begin();
    spi_byte(8'h54); spi_byte(8'hAA); spi_byte(8'h55);
    spi_end();
    tick(50);
    tests_run++;
    if (obs_q.size() != 2 || erase_state !== 2'd1) begin
      tests_failed++; $display("FAIL force_held got writes=%0d state=%0d want writes=2 state=1", obs_q.size(), erase_state);
    end
    spi_cmd1(8'h53, 8'h00);
    wait_idle(500, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL force_idle_timeout got busy want idle"); end
    exp_q = '{{25'h200000, 8'hAA}, {25'h200001, 8'h55},
              {25'h1a0000, 8'h00}, {25'h1a0001, 8'h00}, {25'h1a0002, 8'h00},
              {25'h1a0003, 8'h00}};
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL force_write_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++; $display("FAIL force_write[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_index_reset();
    spi_cmd1(8'h55, 8'h3F);
    tests_run++;
    if (index !== 5'h1F) begin tests_failed++; $display("FAIL idx_load got %h want 1f", index); end
    obs_q.delete(); obs_t.delete();
    spi_begin();
    spi_byte(8'h54);
    spi_bits(8'hAA, 4);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    tests_run++;
    if (index !== 5'd0 || wr !== 1'b0 || size !== '0) begin
      tests_failed++; $display("FAIL idx_reset got index=%h wr=%b size=%h want 0 0 0", index, wr, size);
    end
    spi_bits(8'hA0, 4);
    spi_byte(8'h55);
    spi_byte(8'h07);
    spi_end();
    tick(5);
    tests_run++;
    if (index !== 5'd0 || obs_q.size() != 0 || wr !== 1'b0) begin
      tests_failed++; $display("FAIL idx_stray got index=%h writes=%0d wr=%b want 0 0 0", index, obs_q.size(), wr);
    end
    spi_cmd1(8'h55, 8'h07);
    tests_run++;
    if (index !== 5'd7) begin tests_failed++; $display("FAIL idx_resync got %h want 7", index); end
  endtask

  initial begin
    sck = 1'b0; ss = 1'b1; sdi = 1'b0; force_erase = 1'b0; ready = 1'b0;
    reset = 1'b1;
    tick(4);
    reset = 1'b0;
    tick(2);
    test_reset();
    test_rom_download();
    test_tape_patch();
    test_overflow();
    test_force_erase();
    test_index_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
